// File: rtl/csr_arbiter.sv
// -----------------------------------------------------------------------------
// csr_arbiter
//
// Two-master arbiter for a shared 5-bit-address / 8-bit-data CSR bus.
// Each transaction takes three cycles: IDLE (arbitrate and latch the winner's
// request), ADDR (address, write data and write strobe on the bus) and DATA
// (slave read data returned, owner acked). Ties go round-robin. A master may
// hold the bus across back-to-back transactions with its lock input. A lock
// that blocks a waiting master for LOCK_TIMEOUT idle cycles is revoked.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   mX_req                    transaction request, held until mX_ack
//   mX_a, mX_we, mX_wd        address, write enable, write data
//   mX_lock                   keep the grant for the next transaction
//   mX_gnt                    master owns the bus (or holds it via lock)
//   mX_ack                    one-cycle completion pulse (DATA cycle)
//   mX_rd                     read data, valid with mX_ack, held until next ack
//   bus_a, bus_we, bus_wd     shared CSR bus towards the slaves
//   bus_rd                    OR-combined slave read data, one cycle after bus_a
//   lock_timeout              one-cycle pulse when a lock is forcibly revoked
// -----------------------------------------------------------------------------
module csr_arbiter #(
    parameter logic [7:0] LOCK_TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       m0_req,
    input  logic [4:0] m0_a,
    input  logic       m0_we,
    input  logic [7:0] m0_wd,
    input  logic       m0_lock,
    output logic       m0_gnt,
    output logic       m0_ack,
    output logic [7:0] m0_rd,

    input  logic       m1_req,
    input  logic [4:0] m1_a,
    input  logic       m1_we,
    input  logic [7:0] m1_wd,
    input  logic       m1_lock,
    output logic       m1_gnt,
    output logic       m1_ack,
    output logic [7:0] m1_rd,

    output logic [4:0] bus_a,
    output logic       bus_we,
    output logic [7:0] bus_wd,
    input  logic [7:0] bus_rd,

    output logic       lock_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state;
    logic       owner;        // master of the transaction in flight (0 = m0)
    logic       last_served;  // master that won the most recent arbitration
    logic       locked;       // a lock is held by lock_owner
    logic       lock_owner;
    logic [7:0] to_cnt;       // idle cycles the lock has blocked the other master
    logic [7:0] rd0_q;
    logic [7:0] rd1_q;

    // Arbitration terms, evaluated every cycle but only acted on in IDLE.
    logic       lk_req;
    logic       lk_lock;
    logic       oth_req;
    logic       lock_hold;
    logic       to_qual;
    logic [8:0] to_next;
    logic       to_hit;
    logic       elig0;
    logic       elig1;
    logic       any_grant;
    logic       winner;
    logic       own_lock;

    always_comb begin
        lk_req    = lock_owner ? m1_req  : m0_req;
        oth_req   = lock_owner ? m0_req  : m1_req;
        lk_lock   = lock_owner ? m1_lock : m0_lock;
        // A lock only stays in force while its owner keeps lock asserted;
        // once it drops, both masters compete again in the same IDLE cycle.
        lock_hold = locked & lk_lock;
        to_qual   = lock_hold & ~lk_req & oth_req;
        to_next   = {1'b0, to_cnt} + 9'd1;
        to_hit    = to_qual & (to_next >= {1'b0, LOCK_TIMEOUT});
        // While locked only the owner is eligible. On a timeout the owner is
        // not requesting, so nobody is granted and the other master wins the
        // following IDLE cycle.
        elig0     = m0_req & (~lock_hold | ~lock_owner);
        elig1     = m1_req & (~lock_hold |  lock_owner);
        any_grant = elig0 | elig1;
        winner    = (elig0 & elig1) ? ~last_served : elig1;
        own_lock  = owner ? m1_lock : m0_lock;
    end

    // Read data is presented straight from the bus during the ack cycle and
    // from the capture register afterwards, so it is valid together with ack.
    assign m0_rd = m0_ack ? bus_rd : rd0_q;
    assign m1_rd = m1_ack ? bus_rd : rd1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_served  <= 1'b1;
            locked       <= 1'b0;
            lock_owner   <= 1'b0;
            to_cnt       <= 8'd0;
            rd0_q        <= 8'd0;
            rd1_q        <= 8'd0;
            m0_gnt       <= 1'b0;
            m1_gnt       <= 1'b0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            bus_a        <= 5'd0;
            bus_we       <= 1'b0;
            bus_wd       <= 8'd0;
            lock_timeout <= 1'b0;
        end else begin
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            lock_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_grant) begin
                        state       <= ADDR;
                        owner       <= winner;
                        last_served <= winner;
                        m0_gnt      <= ~winner;
                        m1_gnt      <= winner;
                        bus_a       <= winner ? m1_a  : m0_a;
                        bus_we      <= winner ? m1_we : m0_we;
                        bus_wd      <= winner ? m1_wd : m0_wd;
                        // A held lock survives until DATA re-evaluates it.
                        locked      <= lock_hold;
                        to_cnt      <= 8'd0;
                    end else begin
                        bus_a  <= 5'd0;
                        bus_we <= 1'b0;
                        bus_wd <= 8'd0;
                        if (lock_hold && to_hit) begin
                            locked       <= 1'b0;
                            lock_timeout <= 1'b1;
                            to_cnt       <= 8'd0;
                            m0_gnt       <= 1'b0;
                            m1_gnt       <= 1'b0;
                        end else if (lock_hold) begin
                            if (to_qual) begin
                                to_cnt <= to_next[7:0];
                            end
                            m0_gnt <= ~lock_owner;
                            m1_gnt <= lock_owner;
                        end else begin
                            locked <= 1'b0;
                            to_cnt <= 8'd0;
                            m0_gnt <= 1'b0;
                            m1_gnt <= 1'b0;
                        end
                    end
                end

                ADDR: begin
                    state  <= DATA;
                    bus_we <= 1'b0;
                    m0_ack <= ~owner;
                    m1_ack <= owner;
                end

                DATA: begin
                    state <= IDLE;
                    if (owner) begin
                        rd1_q <= bus_rd;
                    end else begin
                        rd0_q <= bus_rd;
                    end
                    locked     <= own_lock;
                    lock_owner <= owner;
                    to_cnt     <= 8'd0;
                    // A locking owner keeps its grant through the idle gap.
                    m0_gnt     <= ~owner & own_lock;
                    m1_gnt     <= owner & own_lock;
                    bus_a      <= 5'd0;
                    bus_we     <= 1'b0;
                    bus_wd     <= 8'd0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_csr_arbiter
//
// Directed scenarios (single read, round-robin writes, locked read-modify-
// write, lock timeout, reset mid-transaction, request dropped after grant)
// followed by a randomized phase scored against a transaction-timing model:
// every grant occupies the bus for three cycles starting at the cycle in which
// it was decided. The slave is a fixed lookup table indexed by the address
// that was on the bus one cycle earlier.
// -----------------------------------------------------------------------------
module tb_csr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_req, m0_we, m0_lock, m0_gnt, m0_ack;
    logic [4:0] m0_a;
    logic [7:0] m0_wd, m0_rd;
    logic       m1_req, m1_we, m1_lock, m1_gnt, m1_ack;
    logic [4:0] m1_a;
    logic [7:0] m1_wd, m1_rd;
    logic [4:0] bus_a;
    logic       bus_we;
    logic [7:0] bus_wd;
    logic [7:0] bus_rd;
    logic       lock_timeout;

    logic [4:0] prev_a;
    logic [7:0] smem [32];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Slave: read data valid one cycle after the address.
    always @(posedge clk) prev_a <= bus_a;
    assign bus_rd = smem[prev_a];

    csr_arbiter #(.LOCK_TIMEOUT(8'd4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_a(m0_a), .m0_we(m0_we), .m0_wd(m0_wd),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_a(m1_a), .m1_we(m1_we), .m1_wd(m1_wd),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rd(m1_rd),
        .bus_a(bus_a), .bus_we(bus_we), .bus_wd(bus_wd), .bus_rd(bus_rd),
        .lock_timeout(lock_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control outputs packed as {m0_gnt, m1_gnt, m0_ack, m1_ack, bus_we, lock_timeout}.
    task automatic ctl(input string tag, input logic [5:0] e);
        chk(tag, 32'({m0_gnt, m1_gnt, m0_ack, m1_ack, bus_we, lock_timeout}), 32'(e));
    endtask

    task automatic set_m(input logic m, input logic req, input logic [4:0] a,
                         input logic we, input logic [7:0] wd, input logic lk);
        if (m) begin
            m1_req = req; m1_a = a; m1_we = we; m1_wd = wd; m1_lock = lk;
        end else begin
            m0_req = req; m0_a = a; m0_we = we; m0_wd = wd; m0_lock = lk;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] cur_a [2];
        logic [7:0] cur_wd [2];
        int         c, t0, free_at, rel;
        logic       last, w, act, busy, e_ack0, e_ack1, twe;
        logic [4:0] ta;
        logic [7:0] twd, er0, er1;

        for (int i = 0; i < 32; i++) smem[i] = 8'($urandom);
        smem[12] = 8'h5a;
        rst = 1'b1;
        set_m(1'b0, 1'b0, 5'd0, 1'b0, 8'd0, 1'b0);
        set_m(1'b1, 1'b0, 5'd0, 1'b0, 8'd0, 1'b0);

        // Reset state
        tick(); tick();
        ctl("reset_ctl", 6'b000000);
        chk("reset_bus_a", 32'(bus_a), 32'(5'd0));
        chk("reset_bus_wd", 32'(bus_wd), 32'(8'd0));
        chk("reset_rd", 32'({m0_rd, m1_rd}), 32'(16'd0));

        // Single m0 read of 0x0c
        rst = 1'b0;
        set_m(1'b0, 1'b1, 5'h0c, 1'b0, 8'h00, 1'b0);
        tick();
        ctl("rd_addr", 6'b100000);
        chk("rd_bus_a", 32'(bus_a), 32'(5'h0c));
        tick();
        ctl("rd_data", 6'b101000);
        chk("rd_m0_rd", 32'(m0_rd), 32'(8'h5a));
        m0_req = 1'b0;
        tick();
        ctl("rd_idle", 6'b000000);
        chk("rd_hold", 32'(m0_rd), 32'(8'h5a));
        chk("rd_idle_bus_a", 32'(bus_a), 32'(5'd0));

        // Both masters write continuously from reset: strict alternation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cur_a[0] = 5'h01; cur_wd[0] = 8'h10;
        cur_a[1] = 5'h02; cur_wd[1] = 8'h20;
        set_m(1'b0, 1'b1, cur_a[0], 1'b1, cur_wd[0], 1'b0);
        set_m(1'b1, 1'b1, cur_a[1], 1'b1, cur_wd[1], 1'b0);
        for (int k = 0; k < 6; k++) begin
            w = k[0];
            tick();
            ctl("rr_addr", w ? 6'b010010 : 6'b100010);
            chk("rr_bus_a", 32'(bus_a), 32'(cur_a[w]));
            chk("rr_bus_wd", 32'(bus_wd), 32'(cur_wd[w]));
            tick();
            ctl("rr_data", w ? 6'b010100 : 6'b101000);
            chk("rr_rd", 32'(w ? m1_rd : m0_rd), 32'(smem[cur_a[w]]));
            cur_a[w] = cur_a[w] + 5'd2;
            cur_wd[w] = cur_wd[w] + 8'd1;
            set_m(w, 1'b1, cur_a[w], 1'b1, cur_wd[w], 1'b0);
            tick();
            ctl("rr_idle", 6'b000000);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;

        // m1 locked read-modify-write of 0x10 while m0 waits
        set_m(1'b1, 1'b1, 5'h10, 1'b0, 8'h00, 1'b1);
        tick();
        ctl("lk_addr1", 6'b010000);
        chk("lk_bus_a1", 32'(bus_a), 32'(5'h10));
        set_m(1'b0, 1'b1, 5'h03, 1'b0, 8'h00, 1'b0);
        tick();
        ctl("lk_data1", 6'b010100);
        chk("lk_rd1", 32'(m1_rd), 32'(smem[16]));
        set_m(1'b1, 1'b1, 5'h10, 1'b1, 8'hc3, 1'b1);
        tick();
        ctl("lk_idle_hold", 6'b010000);
        tick();
        ctl("lk_addr2", 6'b010010);
        chk("lk_bus_a2", 32'(bus_a), 32'(5'h10));
        chk("lk_bus_wd2", 32'(bus_wd), 32'(8'hc3));
        tick();
        ctl("lk_data2", 6'b010100);
        m1_req = 1'b0;
        tick();
        ctl("lk_blocked1", 6'b010000);
        tick();
        ctl("lk_blocked2", 6'b010000);
        m1_lock = 1'b0;
        tick();
        ctl("lk_m0_addr", 6'b100000);
        chk("lk_m0_bus_a", 32'(bus_a), 32'(5'h03));
        tick();
        ctl("lk_m0_data", 6'b101000);
        chk("lk_m0_rd", 32'(m0_rd), 32'(smem[3]));
        m0_req = 1'b0;
        tick();
        ctl("lk_idle", 6'b000000);

        // Lock timeout: m1 holds lock without requesting, m0 waits
        set_m(1'b1, 1'b1, 5'h01, 1'b0, 8'h00, 1'b1);
        tick();
        ctl("to_addr", 6'b010000);
        tick();
        ctl("to_data", 6'b010100);
        m1_req = 1'b0;
        set_m(1'b0, 1'b1, 5'h07, 1'b1, 8'h99, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            tick();
            ctl("to_wait", 6'b010000);
        end
        tick();
        ctl("to_pulse", 6'b000001);
        tick();
        ctl("to_m0_addr", 6'b100010);
        chk("to_bus_a", 32'(bus_a), 32'(5'h07));
        chk("to_bus_wd", 32'(bus_wd), 32'(8'h99));
        m1_lock = 1'b0;
        tick();
        ctl("to_m0_data", 6'b101000);
        m0_req = 1'b0;
        tick();
        ctl("to_idle", 6'b000000);

        // Reset during ADDR of an m0 write
        set_m(1'b0, 1'b1, 5'h05, 1'b1, 8'h77, 1'b0);
        tick();
        ctl("rst_addr", 6'b100010);
        rst = 1'b1;
        tick();
        ctl("rst_abort_ctl", 6'b000000);
        chk("rst_abort_bus", 32'({bus_a, bus_wd}), 32'(13'd0));
        chk("rst_abort_rd", 32'({m0_rd, m1_rd}), 32'(16'd0));
        rst = 1'b0;
        m0_req = 1'b0;
        tick();
        ctl("rst_no_ack1", 6'b000000);
        tick();
        ctl("rst_no_ack2", 6'b000000);

        // Request dropped during ADDR still completes
        set_m(1'b0, 1'b1, 5'h0c, 1'b0, 8'h00, 1'b0);
        tick();
        ctl("drop_addr", 6'b100000);
        m0_req = 1'b0;
        tick();
        ctl("drop_data", 6'b101000);
        chk("drop_rd", 32'(m0_rd), 32'(8'h5a));
        tick();
        ctl("drop_idle", 6'b000000);
        tick();
        ctl("drop_idle2", 6'b000000);

        // Randomized traffic against the transaction-timing model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c = 0; t0 = 0; free_at = 0; last = 1'b1; act = 1'b0; w = 1'b0;
        ta = 5'd0; twe = 1'b0; twd = 8'd0; er0 = 8'd0; er1 = 8'd0;
        for (int i = 0; i < 400; i++) begin
            if (c >= free_at && (m0_req || m1_req)) begin
                w = (m0_req && m1_req) ? ~last : m1_req;
                last = w;
                t0 = c;
                free_at = c + 3;
                act = 1'b1;
                ta  = w ? m1_a  : m0_a;
                twe = w ? m1_we : m0_we;
                twd = w ? m1_wd : m0_wd;
            end
            tick();
            c++;
            rel = c - t0;
            busy = act && (rel == 1 || rel == 2);
            e_ack0 = act && rel == 2 && !w;
            e_ack1 = act && rel == 2 && w;
            if (e_ack0) er0 = smem[ta];
            if (e_ack1) er1 = smem[ta];
            ctl("rnd_ctl", {busy && !w, busy && w, e_ack0, e_ack1, act && rel == 1 && twe, 1'b0});
            chk("rnd_bus_a", 32'(bus_a), 32'(busy ? ta : 5'd0));
            if (act && rel == 1) chk("rnd_bus_wd", 32'(bus_wd), 32'(twd));
            else if (!busy) chk("rnd_bus_wd_idle", 32'(bus_wd), 32'(8'd0));
            chk("rnd_rd", 32'({m0_rd, m1_rd}), 32'({er0, er1}));
            if (e_ack0 || !m0_req)
                set_m(1'b0, ($urandom_range(0, 99) < 55), 5'($urandom), 1'($urandom),
                      8'($urandom), 1'b0);
            if (e_ack1 || !m1_req)
                set_m(1'b1, ($urandom_range(0, 99) < 55), 5'($urandom), 1'($urandom),
                      8'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
